cache_line_writer: RTL and testbench
====================================

CACHE_LINE_WRITER -- requirements
Module: cache_line_writer

Interface
REQ-001 The block SHALL have these ports, in order: clk in 1, posedge system clock; reset in 1, asynchronous active-high reset.
REQ-002 The block SHALL have these write-request ports: wr_valid in 1, word-write request; wr_ready out 1, request accepted when high with wr_valid; wr_way in 1, target way (0/1); wr_offset in 4, byte offset in line; wr_data in 16 (lc3b_word), store data; wr_mask in 2, byte enables, bit0=low byte, bit1=high byte.
REQ-003 The block SHALL have these line-input ports: line0_in in 128 (lc3b_data), current line of way 0; line1_in in 128 (lc3b_data), current line of way 1.
REQ-004 The block SHALL have these fill ports: fill_start in 1, begin 8-beat line fill; fill_way in 1, fill target way; fill_offset in 4, requested byte offset; fill_beat_valid in 1, memory beat present; fill_beat_data in 16, memory beat word.
REQ-005 The block SHALL have these output ports: line_out out 128 (lc3b_data), line to write; way0_we out 1, write strobe for way 0; way1_we out 1, write strobe for way 1; busy out 1, high whenever state != IDLE; fill_done out 1, one-cycle fill-complete pulse.

Function
REQ-006 The FSM SHALL have states IDLE, MERGE, FILL and COMMIT.
REQ-007 In IDLE, fill_start=1 SHALL capture fill_way and fill_offset, clear the beat counter and go to FILL; fill_start SHALL take priority over wr_valid in the same cycle.
REQ-008 wr_ready SHALL be high exactly when state==IDLE && !fill_start.
REQ-009 A handshake (wr_valid && wr_ready) SHALL register way, offset, data and mask, then go to MERGE.
REQ-010 In MERGE, the block SHALL copy the captured way's line_in, replace word index offset[3:1] (bits 16*i+15:16*i) byte-wise per mask, ignore offset[0], and go to COMMIT.
REQ-011 In FILL, each fill_beat_valid SHALL store fill_beat_data into word index = beat pointer and increment the pointer mod 8; cycles without a beat SHALL hold state.
REQ-012 The 8th accepted beat SHALL cause a transition to COMMIT.
REQ-013 COMMIT SHALL last exactly one cycle: line_out = assembled line, way0_we/way1_we = 1 for the captured way only, then go to IDLE.
REQ-014 fill_done SHALL pulse in COMMIT only when COMMIT is entered from FILL.
REQ-015 Word-write latency: handshake in cycle N SHALL produce the we strobe in cycle N+2; back-to-back writes SHALL achieve one write per 3 cycles.
REQ-016 Fill latency: the 8th beat in cycle N SHALL produce the we strobe and fill_done in cycle N+1.
REQ-017 Outside COMMIT, way0_we, way1_we and fill_done SHALL be 0; line_out SHALL hold its last value.
REQ-018 fill_start when not in IDLE SHALL be ignored; fill_beat_valid outside FILL SHALL be ignored.
REQ-019 wr_mask=00 SHALL still commit the unchanged line.

Reset
REQ-020 reset SHALL asynchronously force state to IDLE, line_out=0, we strobes and fill_done to 0, beat pointer to 0, and clear captured request registers.
REQ-021 A reset asserted mid-MERGE or mid-FILL SHALL discard the partial line with no write strobe; wr_ready SHALL be 1 in the first cycle after reset deassertion (absent fill_start).

Configuration
REQ-022 With FILL_CRITICAL_WORD_EN defined, the beat pointer SHALL start at fill_offset[3:1] and wrap 7->0; the fill SHALL still complete after 8 beats.
REQ-023 With FILL_CRITICAL_WORD_EN undefined, the beat pointer SHALL start at 0 and fill_offset SHALL be ignored.

Verification
REQ-024 Full-word write: line0_in=0, write way0 offset 4'h6 data 16'hBEEF mask 11 -> way0_we in cycle N+2, line_out[63:48]=16'hBEEF, all other bits 0.
REQ-025 Byte write: line1_in=all-ones, write way1 offset 4'hB data 16'h1234 mask 01 -> way1_we=1, line_out[95:80]=16'hFF34, other bits 1.
REQ-026 Fill: fill_start way1, beats 16'h0000..16'h0007 with one idle gap -> line_out word i = i, way1_we and fill_done high for one cycle after the 8th beat.
REQ-027 Critical-word fill (macro on): fill_offset=4'hA, beats 16'hA0..16'hA7 -> word5=16'hA0, word7=16'hA2, word0=16'hA3, word4=16'hA7.
REQ-028 Collision and reset: fill_start and wr_valid in the same cycle -> wr_ready=0 and the fill wins; reset after 4 beats -> no we strobe, busy=0, wr_ready=1 next cycle.

Source files
------------

// File: rtl/cache_line_writer.sv
// cache_line_writer: assembles a 128-bit cache line for one of two ways, either by
// merging a single 16-bit store (byte-masked) into the current line or by collecting
// an 8-beat memory fill, then presents it with a one-cycle per-way write strobe.
//
// Optional feature macro: FILL_CRITICAL_WORD_EN
//   defined   - fill beats start at word fill_offset[3:1] and wrap 7->0
//   undefined - fill beats start at word 0, fill_offset ignored
module cache_line_writer (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         wr_way,
  input  logic [3:0]   wr_offset,
  input  logic [15:0]  wr_data,
  input  logic [1:0]   wr_mask,
  input  logic [127:0] line0_in,
  input  logic [127:0] line1_in,
  input  logic         fill_start,
  input  logic         fill_way,
  input  logic [3:0]   fill_offset,
  input  logic         fill_beat_valid,
  input  logic [15:0]  fill_beat_data,
  output logic [127:0] line_out,
  output logic         way0_we,
  output logic         way1_we,
  output logic         busy,
  output logic         fill_done
);

  typedef enum logic [1:0] {
    StIdle,
    StMerge,
    StFill,
    StCommit
  } state_e;

  state_e state_q, state_d;

  logic         way_q, way_d;
  logic [2:0]   word_q, word_d;
  logic [15:0]  data_q, data_d;
  logic [1:0]   mask_q, mask_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] fill_buf_q, fill_buf_d;
  logic [127:0] line_q, line_d;
  logic         from_fill_q, from_fill_d;

  logic [2:0]   fill_start_ptr;
  logic [127:0] merged;
  logic [15:0]  cur_word;
  logic [15:0]  new_word;
  logic [127:0] filled;

`ifdef FILL_CRITICAL_WORD_EN
  // Critical word first: the requested word arrives as the first beat.
  assign fill_start_ptr = fill_offset[3:1];
  logic unused_bits;
  assign unused_bits = fill_offset[0] ^ wr_offset[0];
`else
  assign fill_start_ptr = 3'd0;
  logic unused_bits;
  assign unused_bits = ^{fill_offset, wr_offset[0]};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request, fill buffer and output line registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      way_q       <= 1'b0;
      word_q      <= 3'd0;
      data_q      <= 16'd0;
      mask_q      <= 2'b00;
      ptr_q       <= 3'd0;
      cnt_q       <= 3'd0;
      fill_buf_q  <= 128'd0;
      line_q      <= 128'd0;
      from_fill_q <= 1'b0;
    end else begin
      way_q       <= way_d;
      word_q      <= word_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      fill_buf_q  <= fill_buf_d;
      line_q      <= line_d;
      from_fill_q <= from_fill_d;
    end
  end

  // Next-state and datapath update; line_q only changes on entry to commit.
  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    word_d      = word_q;
    data_d      = data_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    fill_buf_d  = fill_buf_q;
    line_d      = line_q;
    from_fill_d = from_fill_q;

    merged   = way_q ? line1_in : line0_in;
    cur_word = merged[{word_q, 4'b0000} +: 16];
    new_word = cur_word;
    if (mask_q[0]) new_word[7:0]  = data_q[7:0];
    if (mask_q[1]) new_word[15:8] = data_q[15:8];
    merged[{word_q, 4'b0000} +: 16] = new_word;

    filled = fill_buf_q;
    filled[{ptr_q, 4'b0000} +: 16] = fill_beat_data;

    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          way_d       = fill_way;
          ptr_d       = fill_start_ptr;
          cnt_d       = 3'd0;
          from_fill_d = 1'b1;
          state_d     = StFill;
        end else if (wr_valid) begin
          way_d       = wr_way;
          word_d      = wr_offset[3:1];
          data_d      = wr_data;
          mask_d      = wr_mask;
          from_fill_d = 1'b0;
          state_d     = StMerge;
        end
      end
      StMerge: begin
        line_d  = merged;
        state_d = StCommit;
      end
      StFill: begin
        if (fill_beat_valid) begin
          fill_buf_d = filled;
          ptr_d      = ptr_q + 3'd1;
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            line_d  = filled;
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and commit-cycle outputs.
  always_comb begin
    wr_ready  = (state_q == StIdle) && !fill_start;
    busy      = (state_q != StIdle);
    way0_we   = (state_q == StCommit) && !way_q;
    way1_we   = (state_q == StCommit) && way_q;
    fill_done = (state_q == StCommit) && from_fill_q;
    line_out  = line_q;
  end

endmodule

// File: tb/tb_cache_line_writer.sv
// Self-checking bench for cache_line_writer: directed vector table, hand-written
// fill/collision/reset sequences and randomized transactions against a byte-level model.
module tb_cache_line_writer;

  logic         clk;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_way;
  logic [3:0]   wr_offset;
  logic [15:0]  wr_data;
  logic [1:0]   wr_mask;
  logic [127:0] line0_in;
  logic [127:0] line1_in;
  logic         fill_start;
  logic         fill_way;
  logic [3:0]   fill_offset;
  logic         fill_beat_valid;
  logic [15:0]  fill_beat_data;
  logic [127:0] line_out;
  logic         way0_we;
  logic         way1_we;
  logic         busy;
  logic         fill_done;

  int checks = 0;
  int errors = 0;
  logic [127:0] last_line;

  cache_line_writer dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_way         (wr_way),
    .wr_offset      (wr_offset),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .line0_in       (line0_in),
    .line1_in       (line1_in),
    .fill_start     (fill_start),
    .fill_way       (fill_way),
    .fill_offset    (fill_offset),
    .fill_beat_valid(fill_beat_valid),
    .fill_beat_data (fill_beat_data),
    .line_out       (line_out),
    .way0_we        (way0_we),
    .way1_we        (way1_we),
    .busy           (busy),
    .fill_done      (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  typedef struct {
    logic         way;
    logic [3:0]   off;
    logic [15:0]  data;
    logic [1:0]   mask;
    logic [127:0] l0;
    logic [127:0] l1;
    logic [127:0] exp;
  } wvec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Store as bytes: even byte gets data[7:0], odd byte data[15:8].
  function automatic logic [127:0] model_write(input logic [127:0] base, input logic [3:0] off,
                                               input logic [15:0] d, input logic [1:0] m);
    logic [7:0] b [16];
    logic [127:0] r;
    int lo;
    for (int i = 0; i < 16; i++) b[i] = base[8*i +: 8];
    lo = int'(off) & 14;
    if (m[0]) b[lo]     = d[7:0];
    if (m[1]) b[lo + 1] = d[15:8];
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] model_fill(input logic [15:0] beats [8], input logic [3:0] off);
    logic [15:0] w [8];
    logic [127:0] r;
    int start;
`ifdef FILL_CRITICAL_WORD_EN
    start = int'(off) / 2;
`else
    start = 0;
    if (off == 4'hF) start = 0;
`endif
    for (int k = 0; k < 8; k++) w[(start + k) % 8] = beats[k];
    for (int i = 0; i < 8; i++) r[16*i +: 16] = w[i];
    return r;
  endfunction

  task automatic check_idle();
    check("idle_strobes_busy", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    check("idle_line_hold", line_out, last_line);
  endtask

  // Entry and exit: 1 time unit after a rising edge.
  task automatic do_write(input logic way, input logic [3:0] off, input logic [15:0] d,
                          input logic [1:0] m, input logic [127:0] l0, input logic [127:0] l1);
    logic [127:0] exp;
    exp = model_write(way ? l1 : l0, off, d, m);
    line0_in = l0; line1_in = l1;
    wr_valid = 1'b1; wr_way = way; wr_offset = off; wr_data = d; wr_mask = m;
    fill_start = 1'b0;
    fill_beat_valid = 1'($urandom_range(0, 1)); fill_beat_data = 16'($urandom);
    @(negedge clk);
    check_idle();
    check("wr_ready_idle", wr_ready, 1'b1);
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_way = 1'($urandom); wr_offset = 4'($urandom);
    wr_data = 16'($urandom); wr_mask = 2'($urandom);
    fill_start = 1'($urandom_range(0, 1)); fill_beat_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("merge_no_strobe", {way0_we, way1_we, fill_done, busy}, 4'b0001);
    @(posedge clk); #1;
    fill_start = 1'b0; fill_beat_valid = 1'b0;
    line0_in = rand128(); line1_in = rand128();
    @(negedge clk);
    check("wr_we", {way0_we, way1_we}, way ? 2'b01 : 2'b10);
    check("wr_no_fill_done", fill_done, 1'b0);
    check("wr_line", line_out, exp);
    last_line = exp;
    @(posedge clk); #1;
  endtask

  task automatic do_fill(input logic way, input logic [3:0] off, input logic [15:0] beats [8],
                         input logic [7:0] gaps, input logic collide);
    logic [127:0] exp;
    exp = model_fill(beats, off);
    fill_start = 1'b1; fill_way = way; fill_offset = off;
    wr_valid = collide; wr_way = 1'($urandom); wr_offset = 4'($urandom);
    wr_data = 16'($urandom); wr_mask = 2'($urandom);
    fill_beat_valid = 1'($urandom_range(0, 1)); fill_beat_data = 16'($urandom);
    @(negedge clk);
    check_idle();
    check("fill_start_wr_ready", wr_ready, 1'b0);
    @(posedge clk); #1;
    fill_start = 1'b0; wr_valid = 1'b0; fill_way = ~way; fill_offset = 4'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (gaps[k]) begin
        fill_beat_valid = 1'b0; fill_beat_data = 16'($urandom); fill_start = 1'b1;
        @(negedge clk);
        check("fill_gap", {way0_we, way1_we, fill_done, busy}, 4'b0001);
        check("fill_gap_line_hold", line_out, last_line);
        @(posedge clk); #1;
        fill_start = 1'b0;
      end
      fill_beat_valid = 1'b1; fill_beat_data = beats[k];
      @(negedge clk);
      check("fill_beat", {way0_we, way1_we, fill_done, busy}, 4'b0001);
      @(posedge clk); #1;
    end
    fill_beat_valid = 1'b0; fill_beat_data = 16'($urandom);
    @(negedge clk);
    check("fill_we", {way0_we, way1_we}, way ? 2'b01 : 2'b10);
    check("fill_done", fill_done, 1'b1);
    check("fill_line", line_out, exp);
    last_line = exp;
    @(posedge clk); #1;
  endtask

  wvec_t tbl [4];
  logic [15:0] beats [8];

  initial begin
    wr_valid = 0; wr_way = 0; wr_offset = 0; wr_data = 0; wr_mask = 0;
    line0_in = 0; line1_in = 0; fill_start = 0; fill_way = 0; fill_offset = 0;
    fill_beat_valid = 0; fill_beat_data = 0;
    last_line = 128'd0;

    tbl[0] = '{way: 1'b0, off: 4'h6, data: 16'hBEEF, mask: 2'b11,
               l0: 128'd0, l1: {128{1'b1}},
               exp: 128'h0000_0000_0000_0000_BEEF_0000_0000_0000};
    tbl[1] = '{way: 1'b1, off: 4'hB, data: 16'h1234, mask: 2'b01,
               l0: 128'd0, l1: {128{1'b1}},
               exp: 128'hFFFF_FFFF_FF34_FFFF_FFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{way: 1'b0, off: 4'h3, data: 16'hFFFF, mask: 2'b00,
               l0: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, l1: 128'd0,
               exp: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    tbl[3] = '{way: 1'b1, off: 4'h0, data: 16'hCAFE, mask: 2'b10,
               l0: {128{1'b1}}, l1: 128'd0,
               exp: 128'h0000_0000_0000_0000_0000_0000_0000_CA00};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    check("reset_line", line_out, 128'd0);
    check("reset_wr_ready", wr_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back directed writes
    for (int i = 0; i < 4; i++) begin
      do_write(tbl[i].way, tbl[i].off, tbl[i].data, tbl[i].mask, tbl[i].l0, tbl[i].l1);
      check($sformatf("tbl_line_%0d", i), line_out, tbl[i].exp);
    end

    // Fill into way 1 with one idle gap
    for (int i = 0; i < 8; i++) beats[i] = 16'(i);
    do_fill(1'b1, 4'h0, beats, 8'b0001_0000, 1'b0);
    check("fill_seq_line", line_out, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Fill with a nonzero requested offset
    for (int i = 0; i < 8; i++) beats[i] = 16'h00A0 + 16'(i);
    do_fill(1'b0, 4'hA, beats, 8'b0000_0000, 1'b0);
`ifdef FILL_CRITICAL_WORD_EN
    check("crit_fill_line", line_out, 128'h00A2_00A1_00A0_00A7_00A6_00A5_00A4_00A3);
`else
    check("offset_fill_line", line_out, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
`endif

    // Collision then reset after 4 beats
    fill_start = 1'b1; fill_way = 1'b0; fill_offset = 4'h0;
    wr_valid = 1'b1; wr_way = 1'b1; wr_offset = 4'h2; wr_data = 16'h5555; wr_mask = 2'b11;
    @(negedge clk);
    check("collide_wr_ready", wr_ready, 1'b0);
    @(posedge clk); #1;
    fill_start = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_beat_valid = 1'b1; fill_beat_data = 16'h7700 + 16'(k);
      @(negedge clk);
      check("collide_fill_busy", {way0_we, way1_we, fill_done, busy}, 4'b0001);
      @(posedge clk); #1;
    end
    fill_beat_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("midfill_reset_outputs", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    check("midfill_reset_line", line_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    last_line = 128'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_wr_ready", wr_ready, 1'b1);
    check("post_reset_idle", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    @(posedge clk); #1;

    // Reset in the middle of a merge
    do_write(1'b0, 4'h4, 16'h9876, 2'b11, rand128(), rand128());
    line0_in = rand128();
    wr_valid = 1'b1; wr_way = 1'b0; wr_offset = 4'h8; wr_data = 16'h4321; wr_mask = 2'b11;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("midmerge_reset_outputs", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    check("midmerge_reset_line", line_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    last_line = 128'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_merge_reset_wr_ready", wr_ready, 1'b1);
    check("post_merge_reset_idle", {way0_we, way1_we, fill_done, busy}, 4'b0000);
    @(posedge clk); #1;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 2) begin
        do_write(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom), rand128(), rand128());
      end else begin
        for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
        do_fill(1'($urandom), 4'($urandom), beats, 8'($urandom & $urandom),
                1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        fill_beat_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;
        fill_beat_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
